// File: rtl/ll_pkg.sv
// Shared types and widths for the linked-list request arbiter slice.
package ll_pkg;

    localparam int unsigned PTR_WD     = 4;
    localparam int unsigned WR_DATA_WD = 8;

    typedef enum logic [1:0] {
        PUSH_HEAD,
        PUSH_TAIL,
        POP_HEAD_REQ,
        POP_TAIL_REQ
    } t_req_types;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DELIVER
    } t_arb_state;

    // Index width that stays at least one bit for degenerate counts.
    function automatic int unsigned idx_wd(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ll_req_arbiter_if.sv
// Client-side and linked-list-side handshake bundle of the request arbiter.
interface ll_req_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    import ll_pkg::*;

    logic [N_REQ-1:0]      rq_vld;
    t_req_types            rq_type [N_REQ];
    logic [PTR_WD-1:0]     rq_pos  [N_REQ];
    logic [WR_DATA_WD-1:0] rq_data [N_REQ];
    logic [N_REQ-1:0]      rq_gnt;
    logic [N_REQ-1:0]      rsp_vld;
    logic                  rsp_type;
    logic                  rsp_data;
    logic                  rsp_data_vld;
    logic                  rsp_err;
    logic [N_REQ-1:0]      rsp_taken;

    logic                  ll_req_vld;
    t_req_types            ll_req_type;
    logic [PTR_WD-1:0]     ll_req_pos;
    logic [WR_DATA_WD-1:0] ll_req_data;
    logic                  ll_resp_taken;
    logic                  ll_resp_vld;
    logic                  ll_resp_type;
    logic                  ll_resp_data;
    logic                  ll_resp_data_vld;
    logic                  ll_intf_ready;

    modport slave (
        input  rq_vld, rq_type, rq_pos, rq_data, rsp_taken,
               ll_resp_vld, ll_resp_type, ll_resp_data, ll_resp_data_vld, ll_intf_ready,
        output rq_gnt, rsp_vld, rsp_type, rsp_data, rsp_data_vld, rsp_err,
               ll_req_vld, ll_req_type, ll_req_pos, ll_req_data, ll_resp_taken
    );

    modport master (
        output rq_vld, rq_type, rq_pos, rq_data, rsp_taken,
               ll_resp_vld, ll_resp_type, ll_resp_data, ll_resp_data_vld, ll_intf_ready,
        input  rq_gnt, rsp_vld, rsp_type, rsp_data, rsp_data_vld, rsp_err,
               ll_req_vld, ll_req_type, ll_req_pos, ll_req_data, ll_resp_taken
    );

endinterface

// File: rtl/ll_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module ll_rr_pick #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned IDX_WD = 2
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [IDX_WD-1:0] ptr,
    output logic [N_REQ-1:0]  gnt,
    output logic [IDX_WD-1:0] idx
);

    logic              found;
    logic [N_REQ-1:0]  rot;
    int unsigned       sel;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        rot   = '0;
        sel   = 0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            sel = (32'(ptr) + off) % N_REQ;
            rot = req >> sel;
            if (!found && rot[0]) begin
                found = 1'b1;
                gnt   = N_REQ'(1) << sel;
                idx   = IDX_WD'(sel);
            end
        end
    end

endmodule

// File: rtl/ll_req_arbiter.sv
// Round-robin arbiter sharing one linked_list_top port; one transaction in flight.
module ll_req_arbiter
    import ll_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            reset_n,   // active-high despite the name
    ll_req_arbiter_if.slave bus,
    output logic            busy,
    output logic            err_timeout
);

    localparam int unsigned IDX_WD = idx_wd(N_REQ);
    localparam int unsigned CNT_WD = idx_wd(TIMEOUT_CYC);

    t_arb_state            state_q, state_d;
    logic [IDX_WD-1:0]     owner_q, owner_d, rr_q, rr_d;
    logic [CNT_WD-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d, rsp_vld_q, rsp_vld_d;
    logic                  req_vld_q, req_vld_d, taken_q, taken_d;
    t_req_types            req_type_q, req_type_d;
    logic [PTR_WD-1:0]     req_pos_q, req_pos_d;
    logic [WR_DATA_WD-1:0] req_data_q, req_data_d;
    logic                  rsp_type_q, rsp_type_d, rsp_data_q, rsp_data_d;
    logic                  rsp_dv_q, rsp_dv_d, rsp_err_q, rsp_err_d;
    logic                  err_q, err_d;

    logic [N_REQ-1:0]      pick_gnt;
    logic [IDX_WD-1:0]     pick_idx;
    logic                  tmo_hit, owner_taken;

    ll_rr_pick #(.N_REQ(N_REQ), .IDX_WD(IDX_WD)) u_pick (
        .req (bus.rq_vld),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign tmo_hit     = (TIMEOUT_CYC != 0) && (cnt_q == CNT_WD'(TIMEOUT_CYC - 1));
    assign owner_taken = |(bus.rsp_taken & (N_REQ'(1) << owner_q));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        taken_d    = 1'b0;
        req_vld_d  = req_vld_q;
        req_type_d = req_type_q;
        req_pos_d  = req_pos_q;
        req_data_d = req_data_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_type_d = rsp_type_q;
        rsp_data_d = rsp_data_q;
        rsp_dv_d   = rsp_dv_q;
        rsp_err_d  = rsp_err_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.ll_intf_ready && |bus.rq_vld) begin
                    owner_d    = pick_idx;
                    gnt_d      = pick_gnt;
                    req_vld_d  = 1'b1;
                    req_type_d = bus.rq_type[pick_idx];
                    req_pos_d  = bus.rq_pos[pick_idx];
                    req_data_d = bus.rq_data[pick_idx];
                    cnt_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // A real response takes priority over a timeout hitting in the same cycle.
                if (bus.ll_resp_vld) begin
                    req_vld_d  = 1'b0;
                    taken_d    = 1'b1;
                    rsp_vld_d  = N_REQ'(1) << owner_q;
                    rsp_type_d = bus.ll_resp_type;
                    rsp_data_d = bus.ll_resp_data;
                    rsp_dv_d   = bus.ll_resp_data_vld;
                    rsp_err_d  = 1'b0;
                    state_d    = DELIVER;
                end else if (tmo_hit) begin
                    req_vld_d  = 1'b0;
                    err_d      = 1'b1;
                    rsp_vld_d  = N_REQ'(1) << owner_q;
                    rsp_type_d = 1'b0;
                    rsp_data_d = 1'b0;
                    rsp_dv_d   = 1'b0;
                    rsp_err_d  = 1'b1;
                    state_d    = DELIVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DELIVER: begin
                if (owner_taken) begin
                    rsp_vld_d = '0;
                    rsp_err_d = 1'b0;
                    rr_d      = (32'(owner_q) == N_REQ - 1) ? '0 : owner_q + 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            taken_q    <= 1'b0;
            req_vld_q  <= 1'b0;
            req_type_q <= PUSH_HEAD;
            req_pos_q  <= '0;
            req_data_q <= '0;
            rsp_vld_q  <= '0;
            rsp_type_q <= 1'b0;
            rsp_data_q <= 1'b0;
            rsp_dv_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            taken_q    <= taken_d;
            req_vld_q  <= req_vld_d;
            req_type_q <= req_type_d;
            req_pos_q  <= req_pos_d;
            req_data_q <= req_data_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_type_q <= rsp_type_d;
            rsp_data_q <= rsp_data_d;
            rsp_dv_q   <= rsp_dv_d;
            rsp_err_q  <= rsp_err_d;
            err_q      <= err_d;
        end
    end

    assign bus.rq_gnt        = gnt_q;
    assign bus.rsp_vld       = rsp_vld_q;
    assign bus.rsp_type      = rsp_type_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_data_vld  = rsp_dv_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.ll_req_vld    = req_vld_q;
    assign bus.ll_req_type   = req_type_q;
    assign bus.ll_req_pos    = req_pos_q;
    assign bus.ll_req_data   = req_data_q;
    assign bus.ll_resp_taken = taken_q;
    assign busy              = (state_q != IDLE);
    assign err_timeout       = err_q;

endmodule

// File: tb/tb_ll_req_arbiter.sv
// Directed self-checking bench for ll_req_arbiter (N_REQ=4, TIMEOUT_CYC=64).
module tb_ll_req_arbiter;
    import ll_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic busy, err_timeout;
    int   vec = 0;
    int   errs = 0;

    ll_req_arbiter_if #(.N_REQ(4)) bus ();

    ll_req_arbiter #(.N_REQ(4), .TIMEOUT_CYC(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rq_vld = '0;
        bus.rsp_taken = '0;
        bus.ll_resp_vld = 1'b0;
        bus.ll_resp_type = 1'b0;
        bus.ll_resp_data = 1'b0;
        bus.ll_resp_data_vld = 1'b0;
        bus.ll_intf_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.rq_type[i] = t_req_types'(i);
            bus.rq_pos[i]  = PTR_WD'(i + 8);
            bus.rq_data[i] = WR_DATA_WD'(8'h10 + i);
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
    endtask

    // Runs one transaction to completion; idx=-1 if no grant appeared within budget.
    task automatic do_txn(output int idx);
        idx = -1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.rq_gnt != '0) begin
                for (int i = 0; i < 4; i++) if (bus.rq_gnt[i]) idx = i;
                break;
            end
        end
        if (idx < 0) return;
        bus.ll_resp_vld = 1'b1;
        tick();
        bus.ll_resp_vld = 1'b0;
        bus.rsp_taken = bus.rsp_vld;
        tick();
        bus.rsp_taken = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b1;
        tick();
        tick();
        vec++;
        if ({bus.rq_gnt, bus.rsp_vld, bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_err,
             bus.rsp_data_vld, bus.rsp_type, bus.rsp_data, busy, err_timeout} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: gnt=%b rsp_vld=%b req_vld=%b taken=%b err=%b busy=%b tmo=%b, required all 0",
                     bus.rq_gnt, bus.rsp_vld, bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_err, busy, err_timeout);
        end
        vec++;
        if (bus.ll_req_type !== PUSH_HEAD || bus.ll_req_pos !== '0 || bus.ll_req_data !== '0) begin
            errs++;
            $display("FAIL reset_req_bus: type=%0d pos=%0d data=%0d, required 0 0 0",
                     bus.ll_req_type, bus.ll_req_pos, bus.ll_req_data);
        end
        reset_n = 1'b0;
    endtask

    task automatic test_single();
        bus.rq_vld = 4'b0001;
        bus.rq_type[0] = PUSH_HEAD;
        bus.rq_pos[0] = 4'd3;
        bus.rq_data[0] = 8'd5;
        tick();
        bus.rq_vld = '0;
        vec++;
        if (bus.rq_gnt !== 4'b0001 || bus.ll_req_vld !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL single_grant: gnt=%b req_vld=%b busy=%b, required 0001 1 1",
                     bus.rq_gnt, bus.ll_req_vld, busy);
        end
        vec++;
        if (bus.ll_req_type !== PUSH_HEAD || bus.ll_req_pos !== 4'd3 || bus.ll_req_data !== 8'd5) begin
            errs++;
            $display("FAIL single_req_fields: type=%0d pos=%0d data=%0d, required 0 3 5",
                     bus.ll_req_type, bus.ll_req_pos, bus.ll_req_data);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vec++;
            if (bus.rq_gnt !== 4'b0000 || bus.ll_req_vld !== 1'b1 || bus.ll_req_data !== 8'd5) begin
                errs++;
                $display("FAIL single_hold c%0d: gnt=%b req_vld=%b data=%0d, required 0000 1 5",
                         c, bus.rq_gnt, bus.ll_req_vld, bus.ll_req_data);
            end
        end
        bus.ll_resp_vld = 1'b1;
        bus.ll_resp_type = 1'b1;
        bus.ll_resp_data = 1'b1;
        bus.ll_resp_data_vld = 1'b1;
        tick();
        bus.ll_resp_vld = 1'b0;
        bus.ll_resp_type = 1'b0;
        bus.ll_resp_data = 1'b0;
        bus.ll_resp_data_vld = 1'b0;
        vec++;
        if ({bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_vld, bus.rsp_type, bus.rsp_data,
             bus.rsp_data_vld, bus.rsp_err} !== 10'b0_1_0001_1110) begin
            errs++;
            $display("FAIL single_resp: req_vld=%b taken=%b rsp_vld=%b type=%b data=%b dv=%b err=%b, required 0 1 0001 1 1 1 0",
                     bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_vld, bus.rsp_type, bus.rsp_data,
                     bus.rsp_data_vld, bus.rsp_err);
        end
        bus.rsp_taken = 4'b0010;
        tick();
        vec++;
        if (bus.ll_resp_taken !== 1'b0 || bus.rsp_vld !== 4'b0001 || bus.rsp_data_vld !== 1'b1) begin
            errs++;
            $display("FAIL single_hold_rsp: taken=%b rsp_vld=%b dv=%b, required 0 0001 1",
                     bus.ll_resp_taken, bus.rsp_vld, bus.rsp_data_vld);
        end
        bus.rsp_taken = 4'b0001;
        tick();
        bus.rsp_taken = '0;
        vec++;
        if (bus.rsp_vld !== 4'b0000 || busy !== 1'b0 || bus.rsp_err !== 1'b0) begin
            errs++;
            $display("FAIL single_release: rsp_vld=%b busy=%b err=%b, required 0000 0 0",
                     bus.rsp_vld, busy, bus.rsp_err);
        end
    endtask

    task automatic test_rr_all();
        int idx;
        apply_reset();
        bus.rq_vld = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            do_txn(idx);
            vec++;
            if (idx !== t % 4) begin
                errs++;
                $display("FAIL rr_all txn%0d: granted %0d, required %0d", t, idx, t % 4);
            end
        end
        bus.rq_vld = '0;
    endtask

    task automatic test_rr_sparse();
        int idx;
        int exp_seq[3] = '{1, 3, 1};
        apply_reset();
        bus.rq_vld = 4'b0010;
        do_txn(idx);
        vec++;
        if (idx !== exp_seq[0]) begin
            errs++;
            $display("FAIL rr_sparse setup: granted %0d, required %0d", idx, exp_seq[0]);
        end
        bus.rq_vld = 4'b1010;
        for (int t = 1; t < 3; t++) begin
            do_txn(idx);
            vec++;
            if (idx !== exp_seq[t]) begin
                errs++;
                $display("FAIL rr_sparse txn%0d: granted %0d, required %0d", t, idx, exp_seq[t]);
            end
        end
        bus.rq_vld = '0;
    endtask

    task automatic test_not_ready();
        bus.ll_intf_ready = 1'b0;
        bus.rq_vld = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick();
            vec++;
            if (bus.rq_gnt !== 4'b0000 || bus.ll_req_vld !== 1'b0 || busy !== 1'b0) begin
                errs++;
                $display("FAIL not_ready c%0d: gnt=%b req_vld=%b busy=%b, required 0000 0 0",
                         c, bus.rq_gnt, bus.ll_req_vld, busy);
            end
        end
        bus.ll_intf_ready = 1'b1;
        tick();
        bus.rq_vld = '0;
        vec++;
        if (bus.rq_gnt !== 4'b0001 || bus.ll_req_vld !== 1'b1) begin
            errs++;
            $display("FAIL ready_grant: gnt=%b req_vld=%b, required 0001 1", bus.rq_gnt, bus.ll_req_vld);
        end
        bus.ll_resp_vld = 1'b1;
        tick();
        bus.ll_resp_vld = 1'b0;
        bus.rsp_taken = 4'b0001;
        tick();
        bus.rsp_taken = '0;
    endtask

    task automatic test_timeout();
        int high = 0;
        int idx;
        apply_reset();
        bus.rq_vld = 4'b0100;
        tick();
        bus.rq_vld = '0;
        vec++;
        if (bus.rq_gnt !== 4'b0100 || bus.ll_req_vld !== 1'b1) begin
            errs++;
            $display("FAIL tmo_grant: gnt=%b req_vld=%b, required 0100 1", bus.rq_gnt, bus.ll_req_vld);
        end
        high = bus.ll_req_vld ? 1 : 0;
        for (int c = 0; c < 100 && bus.ll_req_vld === 1'b1; c++) begin
            tick();
            if (bus.ll_req_vld === 1'b1) high++;
        end
        vec++;
        if (high !== 64) begin
            errs++;
            $display("FAIL tmo_length: ll_req_vld high %0d cycles, required 64", high);
        end
        vec++;
        if ({bus.rsp_err, bus.rsp_data_vld, bus.rsp_vld, err_timeout, bus.ll_resp_taken} !== 8'b1_0_0100_1_0) begin
            errs++;
            $display("FAIL tmo_resp: err=%b dv=%b rsp_vld=%b tmo=%b taken=%b, required 1 0 0100 1 0",
                     bus.rsp_err, bus.rsp_data_vld, bus.rsp_vld, err_timeout, bus.ll_resp_taken);
        end
        bus.rsp_taken = 4'b0100;
        tick();
        bus.rsp_taken = '0;
        vec++;
        if (bus.rsp_err !== 1'b0 || bus.rsp_vld !== 4'b0000 || err_timeout !== 1'b1) begin
            errs++;
            $display("FAIL tmo_release: err=%b rsp_vld=%b tmo=%b, required 0 0000 1",
                     bus.rsp_err, bus.rsp_vld, err_timeout);
        end
        bus.rq_vld = 4'b0001;
        do_txn(idx);
        bus.rq_vld = '0;
        vec++;
        if (idx !== 0 || err_timeout !== 1'b1) begin
            errs++;
            $display("FAIL tmo_sticky: granted %0d tmo=%b, required 0 1", idx, err_timeout);
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        apply_reset();
        vec++;
        if (err_timeout !== 1'b0) begin
            errs++;
            $display("FAIL tmo_cleared: tmo=%b, required 0", err_timeout);
        end
        bus.rq_vld = 4'b0100;
        do_txn(idx);
        vec++;
        if (idx !== 2) begin
            errs++;
            $display("FAIL mid_setup: granted %0d, required 2", idx);
        end
        bus.rq_vld = 4'b0010;
        tick();
        bus.rq_vld = '0;
        tick();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        vec++;
        if ({bus.rq_gnt, bus.rsp_vld, bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_err, busy} !== '0) begin
            errs++;
            $display("FAIL reset_in_issue: gnt=%b rsp_vld=%b req_vld=%b taken=%b busy=%b, required all 0",
                     bus.rq_gnt, bus.rsp_vld, bus.ll_req_vld, bus.ll_resp_taken, busy);
        end
        tick();
        vec++;
        if (bus.rsp_vld !== 4'b0000 || busy !== 1'b0) begin
            errs++;
            $display("FAIL issue_dropped: rsp_vld=%b busy=%b, required 0000 0", bus.rsp_vld, busy);
        end
        bus.rq_vld = 4'b0100;
        tick();
        bus.rq_vld = '0;
        bus.ll_resp_vld = 1'b1;
        tick();
        bus.ll_resp_vld = 1'b0;
        vec++;
        if (bus.rsp_vld !== 4'b0100) begin
            errs++;
            $display("FAIL mid_deliver: rsp_vld=%b, required 0100", bus.rsp_vld);
        end
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        vec++;
        if ({bus.rq_gnt, bus.rsp_vld, bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_err,
             bus.rsp_data_vld, busy} !== '0) begin
            errs++;
            $display("FAIL reset_in_deliver: gnt=%b rsp_vld=%b req_vld=%b taken=%b dv=%b busy=%b, required all 0",
                     bus.rq_gnt, bus.rsp_vld, bus.ll_req_vld, bus.ll_resp_taken, bus.rsp_data_vld, busy);
        end
        bus.rq_vld = 4'b1111;
        tick();
        bus.rq_vld = '0;
        vec++;
        if (bus.rq_gnt !== 4'b0001) begin
            errs++;
            $display("FAIL post_reset_ptr: gnt=%b, required 0001", bus.rq_gnt);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_rr_all();
        test_rr_sparse();
        test_not_ready();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
